prbs_bit_scheduler: RTL and testbench

//  Sequences the PRBS generator and edge shaper from one dac_clk domain: a 32-bit phase accumulator

---
 rtl/prbs_ctrl_pkg.sv | 21 ++
 rtl/prbs_phase_acc.sv | 35 +++
 rtl/prbs_bit_scheduler.sv | 176 +++++++++++++++++
 tb/tb_prbs_bit_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_ctrl_pkg.sv
// Shared definitions for the PRBS bit scheduler: FSM encodings, default widths and the
// edge-time clamp helper.
package prbs_ctrl_pkg;

  localparam int unsigned DefaultAccW    = 32;
  localparam int unsigned DefaultCntW    = 16;
  localparam logic [7:0]  DefaultMaxEdge = 8'd255;
  localparam logic [7:0]  DefaultEdgeRst = 8'd4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3
  } prbs_state_e;

  function automatic logic [7:0] clamp_edge(input logic [7:0] req, input logic [7:0] max_edge);
    return (req > max_edge) ? max_edge : req;
  endfunction

endpackage

// File: rtl/prbs_phase_acc.sv
// Phase accumulator for the bit-rate NCO: adds the tuning word while enabled and registers
// the wrap carry as a one-cycle bit strobe.
module prbs_phase_acc
  import prbs_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = DefaultAccW
) (
  input  logic             dac_clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] tune_i,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q;
  logic             carry_q;
  logic [ACC_W:0]   sum;

  assign sum     = {1'b0, acc_q} + {1'b0, tune_i};
  assign carry_o = carry_q;

  always_ff @(posedge dac_clk) begin
    if (reset || clear_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (en_i) begin
      acc_q   <= sum[ACC_W-1:0];
      carry_q <= sum[ACC_W];
    end else begin
      carry_q <= 1'b0;
    end
  end

endmodule

// File: rtl/prbs_bit_scheduler.sv
// Bit-rate scheduler for the PRBS core/edge shaper: run/burst/trigger FSM plus shadowed config.
// Define PRBS_TRIG_SYNC_EN to pass trig_in through a 2-flop synchronizer before edge detection.
module prbs_bit_scheduler
  import prbs_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W    = DefaultAccW,
  parameter int unsigned CNT_W    = DefaultCntW,
  parameter logic [7:0]  MAX_EDGE = DefaultMaxEdge,
  parameter logic [7:0]  EDGE_RST = DefaultEdgeRst
) (
  input  logic             dac_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             burst_mode,
  input  logic             trig_mode,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [ACC_W-1:0] cfg_tune_word,
  input  logic [7:0]       cfg_edge_time,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             lfsr_clk_enable,
  output logic             lfsr_load,
  output logic [7:0]       edge_time_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count,
  output logic [2:0]       state_dbg
);

  prbs_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_count_q;
  logic [ACC_W-1:0] tune_q, tune_sh_q;
  logic [7:0]       edge_q, edge_sh_q, drain_q;
  logic             pend_q, load_q;

  logic carry, strobe, burst_hit, run_entry, drain_exit, accept, apply_sh, trig_rise;

`ifdef PRBS_TRIG_SYNC_EN
  logic trig_meta_q, trig_sync_q, trig_prev_q;

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= trig_in;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
    end
  end

  assign trig_rise = trig_sync_q & ~trig_prev_q;
`else
  logic trig_prev_q;

  always_ff @(posedge dac_clk) begin
    if (reset) trig_prev_q <= 1'b0;
    else       trig_prev_q <= trig_in;
  end

  assign trig_rise = trig_in & ~trig_prev_q;
`endif

  prbs_phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .dac_clk (dac_clk),
    .reset   (reset),
    .clear_i (run_entry),
    .en_i    (state_q == StRun),
    .tune_i  (tune_q),
    .carry_o (carry)
  );

  // A finished burst masks any carry landing on the same cycle so exactly burst_len bits go out.
  assign burst_hit  = burst_mode && (bit_count_q == burst_len);
  assign strobe     = carry && (state_q == StRun) && !burst_hit;
  assign drain_exit = (state_q == StDrain) && (drain_q == 8'd0);
  assign cfg_ready  = !pend_q && !reset;
  assign accept     = cfg_valid && cfg_ready;
  assign apply_sh   = pend_q && (strobe || drain_exit);

  always_comb begin
    state_d   = state_q;
    run_entry = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          if (trig_mode) begin
            state_d = StArm;
          end else begin
            state_d   = StRun;
            run_entry = 1'b1;
          end
        end
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (trig_rise) begin
          state_d   = StRun;
          run_entry = 1'b1;
        end
      end
      StRun: begin
        if (!enable || burst_hit) state_d = StDrain;
      end
      StDrain: begin
        if (drain_exit) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      load_q      <= 1'b0;
      bit_count_q <= '0;
      drain_q     <= 8'd0;
      tune_q      <= '0;
      edge_q      <= EDGE_RST;
      tune_sh_q   <= '0;
      edge_sh_q   <= 8'd0;
      pend_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= run_entry;

      if (run_entry) begin
        bit_count_q <= '0;
      end else if (strobe && (bit_count_q != {CNT_W{1'b1}})) begin
        bit_count_q <= bit_count_q + 1'b1;
      end

      // The shaper needs edge_time_out+1 quiet cycles after the last bit.
      if ((state_q == StRun) && (state_d == StDrain)) begin
        drain_q <= edge_q;
      end else if ((state_q == StDrain) && (drain_q != 8'd0)) begin
        drain_q <= drain_q - 8'd1;
      end

      if (apply_sh) begin
        tune_q <= tune_sh_q;
        edge_q <= edge_sh_q;
        pend_q <= 1'b0;
      end

      // During RUN, changes are deferred to the next bit boundary to keep edges glitch-free.
      if (accept) begin
        if (state_q == StRun) begin
          tune_sh_q <= cfg_tune_word;
          edge_sh_q <= clamp_edge(cfg_edge_time, MAX_EDGE);
          pend_q    <= 1'b1;
        end else begin
          tune_q <= cfg_tune_word;
          edge_q <= clamp_edge(cfg_edge_time, MAX_EDGE);
        end
      end
    end
  end

  assign lfsr_clk_enable = strobe;
  assign lfsr_load       = load_q;
  assign edge_time_out   = edge_q;
  assign busy            = (state_q != StIdle);
  assign bit_count       = bit_count_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_prbs_bit_scheduler.sv
// Directed bench for prbs_bit_scheduler with a per-cycle reference model of the scheduling rules.
module tb_prbs_bit_scheduler;

`ifdef PRBS_TRIG_SYNC_EN
  localparam int TRIG_LAT = 2;
`else
  localparam int TRIG_LAT = 0;
`endif
  localparam longint TWO32   = 64'sh1_0000_0000;
  localparam int     CNT_MAX = 65535;
  localparam int     MAXE    = 255;

  logic        dac_clk = 1'b0;
  logic        reset, enable, burst_mode, trig_mode, trig_in, cfg_valid;
  logic [15:0] burst_len;
  logic [31:0] cfg_tune_word;
  logic [7:0]  cfg_edge_time;

  logic        cfg_ready, lfsr_clk_enable, lfsr_load, busy, done;
  logic [7:0]  edge_time_out;
  logic [15:0] bit_count;
  logic [2:0]  state_dbg;

  logic        w64_ready, w64_strobe, w64_load, w64_busy, w64_done;
  logic [7:0]  w64_edge;
  logic [15:0] w64_count;
  logic [2:0]  w64_state;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 dac_clk = ~dac_clk;

  prbs_bit_scheduler dut (
    .dac_clk(dac_clk), .reset(reset), .enable(enable), .burst_mode(burst_mode),
    .trig_mode(trig_mode), .trig_in(trig_in), .burst_len(burst_len),
    .cfg_tune_word(cfg_tune_word), .cfg_edge_time(cfg_edge_time), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .lfsr_clk_enable(lfsr_clk_enable), .lfsr_load(lfsr_load),
    .edge_time_out(edge_time_out), .busy(busy), .done(done), .bit_count(bit_count),
    .state_dbg(state_dbg)
  );

  prbs_bit_scheduler #(.MAX_EDGE(8'd64)) dut64 (
    .dac_clk(dac_clk), .reset(reset), .enable(enable), .burst_mode(burst_mode),
    .trig_mode(trig_mode), .trig_in(trig_in), .burst_len(burst_len),
    .cfg_tune_word(cfg_tune_word), .cfg_edge_time(cfg_edge_time), .cfg_valid(cfg_valid),
    .cfg_ready(w64_ready), .lfsr_clk_enable(w64_strobe), .lfsr_load(w64_load),
    .edge_time_out(w64_edge), .busy(w64_busy), .done(w64_done), .bit_count(w64_count),
    .state_dbg(w64_state)
  );

  // Reference model: state 0 idle, 1 armed, 2 running, 3 draining.
  int     m_st, n_st, m_cnt, n_cnt, m_drain, n_drain, m_edge, n_edge, m_pedge, n_pedge;
  longint m_acc, n_acc, m_tune, n_tune, m_ptune, n_ptune, sum;
  bit     m_carry, n_carry, m_load, n_load, m_pend, n_pend;
  bit [3:0] m_hist, n_hist;
  bit [4:0] hv;
  bit     hit, rise, accept, enter, e_strobe, e_done, e_ready;
  int     req_edge;

  always_comb begin
    n_st = m_st; n_acc = m_acc; n_carry = m_carry; n_cnt = m_cnt; n_drain = m_drain;
    n_load = 1'b0; n_tune = m_tune; n_edge = m_edge; n_pend = m_pend;
    n_ptune = m_ptune; n_pedge = m_pedge;
    hv       = {m_hist, trig_in};
    n_hist   = hv[3:0];
    hit      = burst_mode && (m_cnt == int'(burst_len));
    e_strobe = (m_st == 2) && m_carry && !hit;
    e_done   = (m_st == 3) && (m_drain == 0);
    e_ready  = !m_pend && !reset;
    rise     = hv[TRIG_LAT] && !hv[TRIG_LAT+1];
    accept   = cfg_valid && e_ready;
    req_edge = (int'(cfg_edge_time) > MAXE) ? MAXE : int'(cfg_edge_time);
    enter    = 1'b0;
    sum      = m_acc + m_tune;
    case (m_st)
      0: if (enable) begin
        if (trig_mode) n_st = 1;
        else enter = 1'b1;
      end
      1: if (!enable) n_st = 0;
         else if (rise) enter = 1'b1;
      2: begin
        n_acc   = sum % TWO32;
        n_carry = (sum >= TWO32);
        if (e_strobe && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
        if (!enable || hit) begin
          n_st    = 3;
          n_drain = m_edge;
        end
        if (m_pend && e_strobe) begin
          n_tune = m_ptune; n_edge = m_pedge; n_pend = 1'b0;
        end
      end
      default: begin
        if (e_done) begin
          n_st = 0;
          if (m_pend) begin
            n_tune = m_ptune; n_edge = m_pedge; n_pend = 1'b0;
          end
        end else begin
          n_drain = m_drain - 1;
        end
      end
    endcase
    if (accept) begin
      if (m_st == 2) begin
        n_pend = 1'b1; n_ptune = longint'(cfg_tune_word); n_pedge = req_edge;
      end else begin
        n_tune = longint'(cfg_tune_word); n_edge = req_edge;
      end
    end
    if (enter) begin
      n_st = 2; n_acc = 0; n_carry = 1'b0; n_cnt = 0; n_load = 1'b1;
    end
    if (reset) begin
      n_st = 0; n_acc = 0; n_carry = 1'b0; n_cnt = 0; n_drain = 0; n_load = 1'b0;
      n_tune = 0; n_edge = 4; n_pend = 1'b0; n_ptune = 0; n_pedge = 0; n_hist = '0;
    end
  end

  always @(posedge dac_clk) begin
    m_st <= n_st; m_acc <= n_acc; m_carry <= n_carry; m_cnt <= n_cnt; m_drain <= n_drain;
    m_load <= n_load; m_tune <= n_tune; m_edge <= n_edge; m_pend <= n_pend;
    m_ptune <= n_ptune; m_pedge <= n_pedge; m_hist <= n_hist;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge dac_clk) begin
    if (chk_en) begin
      check("m_strobe", 64'(lfsr_clk_enable), 64'(e_strobe));
      check("m_load", 64'(lfsr_load), 64'(m_load));
      check("m_busy", 64'(busy), 64'(m_st != 0));
      check("m_done", 64'(done), 64'(e_done));
      check("m_count", 64'(bit_count), 64'(m_cnt));
      check("m_edge", 64'(edge_time_out), 64'(m_edge));
      check("m_ready", 64'(cfg_ready), 64'(e_ready));
      check("m_state", 64'(state_dbg), 64'(m_st));
    end
  end

  task automatic step();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic send_cfg(input logic [31:0] tw, input logic [7:0] et);
    int n;
    n = 0;
    cfg_tune_word = tw; cfg_edge_time = et; cfg_valid = 1'b1;
    while (!cfg_ready && n < 300) begin
      step();
      n++;
    end
    check("cfg_accept_bound", 64'(cfg_ready), 64'd1);
    step();
    cfg_valid = 1'b0;
    #1;
  endtask

  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!lfsr_clk_enable && k < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, strobes, drains, dones;
    reset = 1'b1; enable = 1'b0; burst_mode = 1'b0; trig_mode = 1'b0; trig_in = 1'b0;
    burst_len = '0; cfg_tune_word = '0; cfg_edge_time = '0; cfg_valid = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_edge", 64'(edge_time_out), 64'd4);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(bit_count), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd1);

    // 1: continuous run, tune 2^30 -> one bit every 4 cycles
    send_cfg(32'h4000_0000, 8'd4);
    enable = 1'b1;
    step();
    check("t1_load", 64'(lfsr_load), 64'd1);
    wait_strobe(k);
    check("t1_first_lat", 64'(k), 64'd4);
    wait_strobe(k);
    check("t1_period", 64'(k), 64'd4);
    repeat (40) step();
    check("t1_count", 64'(bit_count), 64'd11);
    check("t1_strobe_at_stop", 64'(lfsr_clk_enable), 64'd1);
    enable = 1'b0;
    k = 0;
    do begin step(); k++; end while (!done && k < 20);
    check("t1_drain_len", 64'(k), 64'd5);
    check("t1_final_count", 64'(bit_count), 64'd12);

    // 2: 5-bit burst, tune 2^31, edge 3
    step();
    burst_mode = 1'b1; burst_len = 16'd5;
    send_cfg(32'h8000_0000, 8'd3);
    enable = 1'b1;
    step();
    strobes = 0; drains = 0; dones = 0; k = 0;
    do begin
      step(); k++;
      strobes += int'(lfsr_clk_enable);
      if (state_dbg == 3'd3) begin drains++; enable = 1'b0; end
    end while (!done && k < 100);
    dones = int'(done);
    repeat (3) begin step(); dones += int'(done); end
    check("t2_strobes", 64'(strobes), 64'd5);
    check("t2_drain", 64'(drains), 64'd4);
    check("t2_done_pulses", 64'(dones), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_count", 64'(bit_count), 64'd5);

    // 3: armed, no trigger for 100 cycles, then one trigger pulse
    burst_mode = 1'b0; trig_mode = 1'b1;
    send_cfg(32'h4000_0000, 8'd4);
    enable = 1'b1;
    strobes = 0;
    repeat (100) begin step(); strobes += int'(lfsr_clk_enable); end
    check("t3_no_strobes", 64'(strobes), 64'd0);
    check("t3_armed", 64'(state_dbg), 64'd1);
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    k = 0;
    while (!lfsr_load && k < 10) begin step(); k++; end
    check("t3_trig_lat", 64'(k), 64'(TRIG_LAT));

    // 4: reconfigure mid-run; takes effect on the next bit boundary
    wait_strobe(k);
    check("t4_first_lat", 64'(k), 64'd4);
    cfg_tune_word = 32'h2000_0000; cfg_edge_time = 8'd200; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    #1;
    check("t4_ready_low", 64'(cfg_ready), 64'd0);
    check("t4_edge_held", 64'(edge_time_out), 64'd4);
    wait_strobe(k);
    check("t4_boundary", 64'(k), 64'd3);
    check("t4_ready_at_strobe", 64'(cfg_ready), 64'd0);
    step();
    check("t4_ready_back", 64'(cfg_ready), 64'd1);
    check("t4_edge_new", 64'(edge_time_out), 64'd200);
    check("t4_edge_clamp64", 64'(w64_edge), 64'd64);
    wait_strobe(k);
    check("t4_transition_gap", 64'(k), 64'd6);
    wait_strobe(k);
    check("t4_new_period", 64'(k), 64'd8);
    enable = 1'b0;
    k = 0;
    do begin step(); k++; end while (!done && k < 400);
    check("t4_drain_len", 64'(k), 64'd201);
    step();

    // 5: edge clamp and zero-length burst
    trig_mode = 1'b0;
    send_cfg(32'h4000_0000, 8'd255);
    check("t5_edge255", 64'(edge_time_out), 64'd255);
    check("t5_edge_clamped", 64'(w64_edge), 64'd64);
    burst_mode = 1'b1; burst_len = 16'd0; enable = 1'b1;
    strobes = 0; k = 0;
    do begin
      step(); k++;
      strobes += int'(lfsr_clk_enable);
      if (state_dbg == 3'd3) enable = 1'b0;
    end while (!done && k < 400);
    check("t5_zero_strobes", 64'(strobes), 64'd0);
    check("t5_done", 64'(done), 64'd1);
    repeat (3) step();

    // 6: reset in the middle of a burst
    send_cfg(32'h8000_0000, 8'd4);
    burst_len = 16'd10; enable = 1'b1;
    k = 0;
    while (bit_count != 16'd3 && k < 100) begin step(); k++; end
    check("t6_reached", 64'(bit_count), 64'd3);
    reset = 1'b1; enable = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("t6_strobe", 64'(lfsr_clk_enable), 64'd0);
    check("t6_load", 64'(lfsr_load), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_count", 64'(bit_count), 64'd0);
    check("t6_edge", 64'(edge_time_out), 64'd4);
    check("t6_state", 64'(state_dbg), 64'd0);
    dones = 0; strobes = 0;
    repeat (20) begin step(); dones += int'(done); strobes += int'(lfsr_clk_enable); end
    check("t6_no_done", 64'(dones), 64'd0);
    check("t6_no_strobes", 64'(strobes), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
